// File: rtl/bus_pkg.sv
// Shared definitions for the two-client memory bus arbiter.
//   ADDR_WIDTH / DATA_WIDTH : default line address and cache line widths
//   CL_DCACHE / CL_ICACHE   : client indices on the arbiter's client vectors
//   arb_state_t             : arbiter FSM encoding (also driven on the debug port)
//   client_onehot()         : client index -> one-hot client vector
package bus_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 512;

  localparam int CL_DCACHE = 0;
  localparam int CL_ICACHE = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    DONE     = 3'd4
  } arb_state_t;

  function automatic logic [1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the memory port.
//   master : the arbiter's view (drives reqack/rdata/task_comp and the memory request side)
//   slave  : the environment's view (caches and memory)
//
// Client handshake: a client raises cl_req[n] with cl_rw/cl_addr stable and
// holds it until it has seen cl_reqack[n]; it then drops cl_req[n], with its
// write line valid on cl_wdata no later than that cycle. Completion is a
// single-cycle cl_task_comp[n] pulse; cl_rdata is valid from that pulse on.
// Memory handshake: mem_req is held with rw/addr/wdata stable until mem_ack is
// sampled high; mem_done is a one-cycle pulse carrying mem_rdata for reads.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH
) ();

  logic [1:0]              cl_req;
  logic [1:0]              cl_reqack;
  logic [1:0]              cl_rw;
  logic [2*ADDR_WIDTH-1:0] cl_addr;
  logic [2*DATA_WIDTH-1:0] cl_wdata;
  logic [DATA_WIDTH-1:0]   cl_rdata;
  logic [1:0]              cl_task_comp;

  logic                    mem_req;
  logic                    mem_ack;
  logic                    mem_rw;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_done;

  logic                    timeout_err;

  modport master (
    input  cl_req, cl_rw, cl_addr, cl_wdata, mem_ack, mem_rdata, mem_done,
    output cl_reqack, cl_rdata, cl_task_comp, mem_req, mem_rw, mem_addr,
           mem_wdata, timeout_err
  );

  modport slave (
    output cl_req, cl_rw, cl_addr, cl_wdata, mem_ack, mem_rdata, mem_done,
    input  cl_reqack, cl_rdata, cl_task_comp, mem_req, mem_rw, mem_addr,
           mem_wdata, timeout_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker.
//   req        : request vector, bit n = client n
//   last_grant : index of the client granted most recently
//   grant      : one-hot winner (all zero when nothing is requested)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the client that did not win last time goes first.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-client memory bus arbiter: grants one cache-line transaction at a time
// (client 0 = dcache, client 1 = icache) to a single memory port, round-robin
// between clients, with a watchdog on the memory response.
//   clk, reset : clock, synchronous active-high reset
//   bus        : client and memory bus bundle (master view)
//   state_dbg  : current FSM state
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus,
  output arb_state_t        state_dbg
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic             g_q;         // granted client index
  logic             last_grant;  // round-robin pointer
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       pick;

  rr_arbiter2 u_rr (
    .req        (bus.cl_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      g_q              <= 1'b0;
      last_grant       <= 1'b1;  // makes client 0 win the first contention
      wait_cnt         <= '0;
      bus.cl_reqack    <= '0;
      bus.cl_task_comp <= '0;
      bus.cl_rdata     <= '0;
      bus.mem_req      <= 1'b0;
      bus.mem_rw       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.timeout_err  <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      bus.cl_task_comp <= '0;
      bus.timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (|pick) begin
            g_q        <= pick[1];
            bus.mem_rw <= bus.cl_rw[pick[1]];
            bus.mem_addr <= pick[1] ? bus.cl_addr[CL_ICACHE*ADDR_WIDTH +: ADDR_WIDTH]
                                    : bus.cl_addr[CL_DCACHE*ADDR_WIDTH +: ADDR_WIDTH];
            state      <= GRANT;
          end
        end

        GRANT: begin
          if (bus.cl_req[g_q]) begin
            bus.cl_reqack <= client_onehot(g_q);
          end else begin
            // The drop of req is the point where the write line is valid.
            bus.cl_reqack <= '0;
            bus.mem_wdata <= g_q ? bus.cl_wdata[CL_ICACHE*DATA_WIDTH +: DATA_WIDTH]
                                 : bus.cl_wdata[CL_DCACHE*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_req   <= 1'b1;
            state         <= MEM_REQ;
          end
        end

        MEM_REQ: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            wait_cnt    <= '0;
            // A completion arriving with the accept is taken immediately.
            if (bus.mem_done) begin
              if (bus.mem_rw) bus.cl_rdata <= bus.mem_rdata;
              state <= DONE;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end

        MEM_WAIT: begin
          if (bus.mem_done) begin
            if (bus.mem_rw) bus.cl_rdata <= bus.mem_rdata;
            state <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            state           <= DONE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          bus.cl_task_comp <= client_onehot(g_q);
          last_grant       <= g_q;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT = 8. The bench plays both
// cache clients and the memory; inputs change and outputs are sampled on the
// falling clock edge.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  arb_state_t state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected cl_task_comp vector for each transaction in flight.
  logic [1:0] exp_q[$];

  typedef struct {
    bit          client;
    bit          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;      // returned by memory on mem_done
    int          lat;        // cycles after accept until mem_done
    logic [DW-1:0] exp_rdata;  // cl_rdata after completion
  } vec_t;

  vec_t vecs[5];

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reqack"},    bus.cl_reqack, 2'b00);
    check({tag, "_task_comp"}, bus.cl_task_comp, 2'b00);
    check({tag, "_mem_req"},   bus.mem_req, 1'b0);
    check({tag, "_mem_rw"},    bus.mem_rw, 1'b0);
    check({tag, "_timeout"},   bus.timeout_err, 1'b0);
    check({tag, "_mem_addr"},  bus.mem_addr, '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check({tag, "_rdata"},     bus.cl_rdata, '0);
    check({tag, "_state"},     state_dbg, IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_client(input bit c, input bit rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    int i;
    i = int'(c);
    bus.cl_rw[i]               = rw;
    bus.cl_addr[i*AW +: AW]    = addr;
    bus.cl_wdata[i*DW +: DW]   = wdata;
  endtask

  // One full transaction for client c. mode 0: mem_done lat cycles after the
  // accept; mode 1: mem_ack and mem_done together; mode 2: mem_done never comes.
  // keep_req re-raises the client's request right after its drop (back-to-back
  // traffic); otherwise all requests are cleared when task_comp is seen.
  task automatic do_txn(input bit c, input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int lat, input int mode, input bit keep_req,
                        input logic [DW-1:0] exp_rdata);
    int         cyc;
    int         te_seen;
    int         te_cyc;
    int         exp_lat;
    logic [1:0] oh;
    oh = c ? 2'b10 : 2'b01;
    exp_q.push_back(oh);
    // Write line deliberately wrong until the drop cycle.
    set_client(c, rw, addr, ~wdata);
    bus.cl_req[c] = 1'b1;

    cyc = 0;
    while (bus.cl_reqack == 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("reqack", bus.cl_reqack, oh);

    set_client(c, rw, addr, wdata);
    bus.cl_req[c] = 1'b0;
    @(negedge clk);
    check("reqack_low", bus.cl_reqack, 2'b00);
    check("mem_req", bus.mem_req, 1'b1);
    check("mem_rw", bus.mem_rw, rw);
    check("mem_addr", bus.mem_addr, addr);
    if (!rw) check("mem_wdata", bus.mem_wdata, wdata);
    if (keep_req) bus.cl_req[c] = 1'b1;

    bus.mem_ack = 1'b1;
    if (mode == 1) begin
      bus.mem_done  = 1'b1;
      bus.mem_rdata = rdata;
    end
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b0;
    check("mem_req_clr", bus.mem_req, 1'b0);

    cyc     = 1;
    te_seen = 0;
    te_cyc  = 0;
    while (bus.cl_task_comp == 2'b00 && cyc < 40) begin
      bus.mem_done  = (mode == 0 && cyc == lat);
      bus.mem_rdata = bus.mem_done ? rdata : ~rdata;
      @(negedge clk);
      cyc++;
      if (bus.timeout_err) begin
        te_seen++;
        te_cyc = cyc;
      end
    end
    bus.mem_done = 1'b0;

    exp_lat = (mode == 0) ? lat + 2 : (mode == 1) ? 2 : TO + 2;
    check("latency", cyc, exp_lat);
    check("task_comp", bus.cl_task_comp, exp_q.pop_front());
    check("rdata", bus.cl_rdata, exp_rdata);
    check("timeout_pulses", te_seen, (mode == 2) ? 1 : 0);
    if (mode == 2) check("timeout_cycle", te_cyc, TO + 1);
    if (!keep_req) bus.cl_req = 2'b00;

    @(negedge clk);
    check("task_comp_once", bus.cl_task_comp, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] r1, r2, r3, r4, pa5, pw1, p2, pw3, p9, psc, p7, junk;
    int cyc;

    r1   = {16{32'h1111_0001}};
    r2   = {16{32'h2222_0002}};
    r3   = {16{32'h3333_0003}};
    r4   = {16{32'h4444_0004}};
    pa5  = {64{8'hA5}};
    pw1  = {16{32'hDEAD_BEEF}};
    p2   = {8{64'h0123_4567_89AB_CDEF}};
    pw3  = {64{8'h3C}};
    p9   = {128{4'h9}};
    psc  = {8{64'hFEED_FACE_0BAD_F00D}};
    p7   = {32{16'h7007}};
    junk = {64{8'hFF}};

    vecs[0] = '{client: 1'b0, rw: 1'b1, addr: 64'h40,   wdata: '0,  rdata: pa5,  lat: 3, exp_rdata: pa5};
    vecs[1] = '{client: 1'b0, rw: 1'b0, addr: 64'h80,   wdata: pw1, rdata: junk, lat: 2, exp_rdata: pa5};
    vecs[2] = '{client: 1'b1, rw: 1'b1, addr: 64'h1000, wdata: '0,  rdata: p2,   lat: 1, exp_rdata: p2};
    vecs[3] = '{client: 1'b1, rw: 1'b0, addr: 64'h2000, wdata: pw3, rdata: junk, lat: 4, exp_rdata: p2};
    vecs[4] = '{client: 1'b0, rw: 1'b1, addr: 64'hFFFF_FFFF_FFFF_FFC0, wdata: '0, rdata: p9, lat: 1, exp_rdata: p9};

    bus.cl_req    = 2'b00;
    bus.cl_rw     = 2'b00;
    bus.cl_addr   = '0;
    bus.cl_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Both clients requesting continuously: grants alternate 0,1,0,1.
    set_client(1'b0, 1'b1, 64'h100, '0);
    set_client(1'b1, 1'b1, 64'h200, '0);
    bus.cl_req = 2'b11;
    do_txn(1'b0, 1'b1, 64'h100, '0, r1, 1, 0, 1'b1, r1);
    do_txn(1'b1, 1'b1, 64'h200, '0, r2, 1, 0, 1'b1, r2);
    do_txn(1'b0, 1'b1, 64'h100, '0, r3, 1, 0, 1'b1, r3);
    do_txn(1'b1, 1'b1, 64'h200, '0, r4, 1, 0, 1'b0, r4);

    // Table of single-client reads and writes.
    for (int i = 0; i < 5; i++)
      do_txn(vecs[i].client, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].lat, 0, 1'b0, vecs[i].exp_rdata);

    // Accept and completion in the same cycle.
    do_txn(1'b1, 1'b1, 64'h3C0, '0, psc, 1, 1, 1'b0, psc);

    // No completion: watchdog fires, read data untouched.
    do_txn(1'b0, 1'b1, 64'h500, '0, junk, 1, 2, 1'b0, psc);

    // A stray completion while idle changes nothing.
    bus.mem_done  = 1'b1;
    bus.mem_rdata = junk;
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("stray_done_state", state_dbg, IDLE);
    check("stray_done_rdata", bus.cl_rdata, psc);
    @(negedge clk);
    check("stray_done_tc", bus.cl_task_comp, 2'b00);

    // Next request after the timeout is served normally (client 0 last).
    do_txn(1'b0, 1'b0, 64'h600, pw1, junk, 2, 0, 1'b0, psc);

    // Reset while client 1 waits on memory.
    set_client(1'b1, 1'b1, 64'h800, '0);
    bus.cl_req = 2'b10;
    cyc = 0;
    while (bus.cl_reqack != 2'b10 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mr_reqack", bus.cl_reqack, 2'b10);
    bus.cl_req = 2'b00;
    cyc = 0;
    while (!bus.mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mr_mem_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_state", state_dbg, MEM_WAIT);
    set_client(1'b0, 1'b1, 64'h700, '0);
    set_client(1'b1, 1'b1, 64'h900, '0);
    bus.cl_req = 2'b11;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    // Pointer was left favouring client 1; reset must hand the first grant to client 0.
    do_txn(1'b0, 1'b1, 64'h700, '0, p7, 1, 0, 1'b0, p7);

    repeat (2) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
